// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR word generator.
//   lfsr_state_e : FSM states (IDLE/FILL/HOLD)
//   MODE_*       : feedback structure selector
//   *_TAPS_* / *_POLY_* : known-good maximal-length feedback sets per width
package lfsr_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_HOLD} lfsr_state_e;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  // Fibonacci: bit k set -> state[k] feeds the XOR.
  localparam logic [7:0]  FIB_TAPS_8  = 8'hB8;
  localparam logic [15:0] FIB_TAPS_16 = 16'hD008;
  localparam logic [25:0] FIB_TAPS_26 = 26'h20000C1;
  localparam logic [31:0] FIB_TAPS_32 = 32'h80200003;

  // Galois: low-order polynomial coefficients, x^WIDTH implied.
  localparam logic [7:0]  GAL_POLY_8  = 8'h1D;
  localparam logic [15:0] GAL_POLY_16 = 16'h002D;
  localparam logic [25:0] GAL_POLY_26 = 26'h0000183;
  localparam logic [31:0] GAL_POLY_32 = 32'h000000C5;

endpackage

// File: rtl/lfsr_word_gen_if.sv
// Control/handshake bundle of lfsr_word_gen.
//   master : the generator (drives word/valid/status, takes control + ready)
//   slave  : the controller/consumer side
interface lfsr_word_gen_if #(
  parameter int WIDTH = 26,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  logic             p_load;
  logic [WIDTH-1:0] p_din;
  logic             p_start;
  logic [CNT_W-1:0] p_run_len;
  logic             p_stop;
  logic [OUT_W-1:0] p_word;
  logic             p_valid;
  logic             p_ready;
  logic             p_busy;
  logic             p_done;
  logic             p_lock_err;
  logic [WIDTH-1:0] p_state;

  modport master (
    input  p_load, p_din, p_start, p_run_len, p_stop, p_ready,
    output p_word, p_valid, p_busy, p_done, p_lock_err, p_state
  );

  modport slave (
    output p_load, p_din, p_start, p_run_len, p_stop, p_ready,
    input  p_word, p_valid, p_busy, p_done, p_lock_err, p_state
  );
endinterface

// File: rtl/lfsr_step.sv
// One LFSR step, purely combinational.
//   state   : current register value
//   next    : value after one shift
//   out_bit : serial output bit (MSB before the shift)
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 26,
  parameter int               MODE     = MODE_FIB,
  parameter logic [WIDTH-1:0] FIB_TAPS = FIB_TAPS_26,
  parameter logic [WIDTH-1:0] GAL_POLY = GAL_POLY_26
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next,
  output logic             out_bit
);

  assign out_bit = state[WIDTH-1];

  generate
    if (MODE == MODE_GAL) begin : g_gal
      assign next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GAL_POLY : '0);
    end else begin : g_fib
      assign next = {state[WIDTH-2:0], ^(state & FIB_TAPS)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_word_gen.sv
// Word-serialised LFSR pattern source.
// Packs OUT_W successive LFSR output bits (first bit in the MSB) into a word
// and offers it on a valid/ready handshake. Runs for p_run_len words, or
// free-runs (p_run_len=0) until p_stop lands on a word boundary.
//   p_clk_in, p_rst_n : clock, async active-low reset
//   bus (master)      : load/seed, start/run_len/stop, word/valid/ready,
//                       busy/done/lock_err status, raw state observation
module lfsr_word_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 26,
  parameter int               OUT_W    = 8,
  parameter int               MODE     = MODE_FIB,
  parameter logic [WIDTH-1:0] FIB_TAPS = FIB_TAPS_26,
  parameter logic [WIDTH-1:0] GAL_POLY = GAL_POLY_26,
  parameter logic [WIDTH-1:0] DEF_SEED = '1,
  parameter int               CNT_W    = 16
) (
  input logic             p_clk_in,
  input logic             p_rst_n,
  lfsr_word_gen_if.master bus
);

  localparam int BC_W = $clog2(OUT_W + 1);

  lfsr_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_nxt;
  logic             out_bit;
  logic [BC_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [OUT_W-1:0] word_q;
  logic [OUT_W:0]   word_sh;
  logic             valid_q, done_q, lock_err_q, stop_pend_q;
  logic             last_bit, free_run, run_end, seed_zero;

  lfsr_step #(
    .WIDTH(WIDTH), .MODE(MODE), .FIB_TAPS(FIB_TAPS), .GAL_POLY(GAL_POLY)
  ) u_step (
    .state(state_q), .next(state_nxt), .out_bit(out_bit)
  );

  assign last_bit  = (bit_cnt_q == BC_W'(OUT_W - 1));
  // word_cnt holds the remaining count of a fixed run; a run started with
  // length 0 keeps it at 0 for its whole life, which marks free-run.
  assign free_run  = (word_cnt_q == '0);
  // A stop arriving in the handshake cycle itself is honoured too.
  assign run_end   = free_run ? (stop_pend_q | bus.p_stop)
                              : (word_cnt_q == CNT_W'(1));
  assign word_sh   = {word_q, out_bit};
  assign seed_zero = (bus.p_din == '0);

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (bus.p_start) fsm_d = ST_FILL;
      ST_FILL: if (last_bit)    fsm_d = ST_HOLD;
      ST_HOLD: if (bus.p_ready) fsm_d = run_end ? ST_IDLE : ST_FILL;
      default:                  fsm_d = ST_IDLE;
    endcase
    if (bus.p_load) fsm_d = ST_IDLE;
  end

  always_ff @(posedge p_clk_in or negedge p_rst_n) begin
    if (!p_rst_n) fsm_q <= ST_IDLE;
    else          fsm_q <= fsm_d;
  end

  always_ff @(posedge p_clk_in or negedge p_rst_n) begin
    if (!p_rst_n) begin
      state_q     <= DEF_SEED;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      lock_err_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.p_load) begin
        // A zero seed would lock the register; substitute and flag it.
        state_q     <= seed_zero ? DEF_SEED : bus.p_din;
        if (seed_zero) lock_err_q <= 1'b1;
        bit_cnt_q   <= '0;
        word_cnt_q  <= '0;
        valid_q     <= 1'b0;
        stop_pend_q <= 1'b0;
      end else begin
        if (fsm_q != ST_IDLE && bus.p_stop) stop_pend_q <= 1'b1;
        case (fsm_q)
          ST_IDLE: begin
            if (bus.p_start) begin
              bit_cnt_q  <= '0;
              word_cnt_q <= bus.p_run_len;
            end
          end
          ST_FILL: begin
            state_q   <= state_nxt;
            word_q    <= word_sh[OUT_W-1:0];
            bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            if (last_bit) valid_q <= 1'b1;
          end
          ST_HOLD: begin
            if (bus.p_ready) begin
              valid_q <= 1'b0;
              if (!free_run) word_cnt_q <= word_cnt_q - 1'b1;
              if (run_end) begin
                done_q      <= 1'b1;
                stop_pend_q <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.p_word     = word_q;
  assign bus.p_valid    = valid_q;
  assign bus.p_busy     = (fsm_q != ST_IDLE);
  assign bus.p_done     = done_q;
  assign bus.p_lock_err = lock_err_q;
  assign bus.p_state    = state_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Scoreboard bench for lfsr_word_gen: a 26-bit Fibonacci instance and an
// 8-bit Galois instance. Expected words are hand-derived and queued by the
// stimulus; monitors compare whatever the DUTs present on valid.
module tb_lfsr_word_gen;
  import lfsr_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_word_gen_if #(.WIDTH(26), .OUT_W(8), .CNT_W(16)) ifa ();
  lfsr_word_gen_if #(.WIDTH(8),  .OUT_W(8), .CNT_W(16)) ifb ();

  lfsr_word_gen #(
    .WIDTH(26), .OUT_W(8), .MODE(MODE_FIB), .FIB_TAPS(26'h20000C1),
    .GAL_POLY(26'h0000183), .DEF_SEED(26'h3FFFFFF), .CNT_W(16)
  ) u_dut (.p_clk_in(clk), .p_rst_n(rst_n), .bus(ifa));

  lfsr_word_gen #(
    .WIDTH(8), .OUT_W(8), .MODE(MODE_GAL), .FIB_TAPS(8'hB8),
    .GAL_POLY(8'h1D), .DEF_SEED(8'hFF), .CNT_W(16)
  ) u_gal (.p_clk_in(clk), .p_rst_n(rst_n), .bus(ifb));

  typedef struct {
    logic [31:0] word;
    logic [31:0] st;
    bit          chk_st;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_chk = 0, n_err = 0;
  int done_a = 0, done_b = 0, hs_a = 0, hs_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: sample at the falling edge, handshake happens on the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.p_done) done_a++;
      if (ifa.p_valid) begin
        if (qa.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL a_extra_word: got %0h expected no word", ifa.p_word);
        end else begin
          chk("a_word", ifa.p_word, qa[0].word);
          if (qa[0].chk_st) chk("a_state", ifa.p_state, qa[0].st);
          if (ifa.p_ready) begin void'(qa.pop_front()); hs_a++; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifb.p_done) done_b++;
      if (ifb.p_valid) begin
        if (qb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL b_extra_word: got %0h expected no word", ifb.p_word);
        end else begin
          chk("b_word", ifb.p_word, qb[0].word);
          if (qb[0].chk_st) chk("b_state", ifb.p_state, qb[0].st);
          if (ifb.p_ready) begin void'(qb.pop_front()); hs_b++; end
        end
      end
    end
  end

  task automatic step(input int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // which: 0 a.valid, 1 a.done, 2 b.valid, 3 b.done
  task automatic wait_for(input int which, input int lim, output int n);
    logic s;
    n = 0;
    s = 1'b0;
    do begin
      step();
      n++;
      case (which)
        0: s = ifa.p_valid;
        1: s = ifa.p_done;
        2: s = ifb.p_valid;
        default: s = ifb.p_done;
      endcase
    end while (!s && n < lim);
    if (!s) begin
      n_chk++; n_err++;
      $display("FAIL timeout_%0d: got no event expected one within %0d cycles", which, lim);
    end
  endtask

  task automatic load_a(input logic [25:0] v);
    ifa.p_din = v; ifa.p_load = 1'b1; step(); ifa.p_load = 1'b0;
  endtask

  task automatic start_a(input logic [15:0] len);
    ifa.p_run_len = len; ifa.p_start = 1'b1; step(); ifa.p_start = 1'b0;
  endtask

  initial begin
    int n, lat, h0, d0;
    ifa.p_load = 0; ifa.p_din = '0; ifa.p_start = 0; ifa.p_run_len = '0;
    ifa.p_stop = 0; ifa.p_ready = 1;
    ifb.p_load = 0; ifb.p_din = '0; ifb.p_start = 0; ifb.p_run_len = '0;
    ifb.p_stop = 0; ifb.p_ready = 1;

    // Reset state
    #12;
    chk("rst_state",    ifa.p_state, 26'h3FFFFFF);
    chk("rst_word",     ifa.p_word, 0);
    chk("rst_valid",    ifa.p_valid, 0);
    chk("rst_busy",     ifa.p_busy, 0);
    chk("rst_done",     ifa.p_done, 0);
    chk("rst_lock",     ifa.p_lock_err, 0);
    chk("rst_b_state",  ifb.p_state, 8'hFF);
    @(negedge clk); rst_n = 1'b1;
    step();

    // All-ones seed, one word: latency, done timing
    load_a(26'h3FFFFFF);
    qa.push_back('{word: 32'hFF, st: 32'h3FFFF54, chk_st: 1'b1});
    start_a(16'd1);
    lat = 1;
    while (!ifa.p_valid && lat < 20) begin step(); lat++; end
    chk("a_latency", lat, 9);
    chk("a_busy_hold", ifa.p_busy, 1);
    step();
    chk("a_done_pulse", ifa.p_done, 1);
    chk("a_valid_drop", ifa.p_valid, 0);
    step();
    chk("a_done_one_cycle", ifa.p_done, 0);
    chk("a_busy_after", ifa.p_busy, 0);
    chk("a_done_count1", done_a, 1);

    // Galois 8-bit: 01 -> word 01, state 1D
    ifb.p_din = 8'h01; ifb.p_load = 1'b1; step(); ifb.p_load = 1'b0;
    qb.push_back('{word: 32'h01, st: 32'h1D, chk_st: 1'b1});
    ifb.p_run_len = 16'd1; ifb.p_start = 1'b1; step(); ifb.p_start = 1'b0;
    wait_for(3, 30, n);
    step();
    chk("b_busy_after", ifb.p_busy, 0);
    chk("b_state_end", ifb.p_state, 8'h1D);
    chk("b_done_count", done_b, 1);

    // Zero seed protection, sticky flag
    load_a(26'h0);
    chk("lock_state", ifa.p_state, 26'h3FFFFFF);
    chk("lock_set", ifa.p_lock_err, 1);
    load_a(26'h1234567);
    chk("lock_sticky", ifa.p_lock_err, 1);
    chk("load_state", ifa.p_state, 26'h1234567);

    // Three-word run, consumer stalls 5 cycles on the first word
    h0 = hs_a; d0 = done_a;
    qa.push_back('{word: 32'h48, st: 32'h3456741, chk_st: 1'b1});
    qa.push_back('{word: 32'hD1, st: 32'h0, chk_st: 1'b0});
    qa.push_back('{word: 32'h59, st: 32'h0, chk_st: 1'b0});
    ifa.p_ready = 1'b0;
    start_a(16'd3);
    wait_for(0, 20, n);
    step(5);
    chk("stall_valid", ifa.p_valid, 1);
    ifa.p_ready = 1'b1;
    wait_for(1, 100, n);
    step();
    chk("run3_handshakes", hs_a - h0, 3);
    chk("run3_done", done_a - d0, 1);
    chk("run3_queue", qa.size(), 0);

    // Free-run, stop raised mid-FILL of word 2
    load_a(26'h1234567);
    h0 = hs_a; d0 = done_a;
    qa.push_back('{word: 32'h48, st: 32'h3456741, chk_st: 1'b1});
    qa.push_back('{word: 32'hD1, st: 32'h0, chk_st: 1'b0});
    start_a(16'd0);
    wait_for(0, 20, n);
    step(2);
    chk("free_busy_fill", ifa.p_busy, 1);
    ifa.p_stop = 1'b1; step(); ifa.p_stop = 1'b0;
    wait_for(1, 40, n);
    step();
    chk("free_handshakes", hs_a - h0, 2);
    chk("free_done", done_a - d0, 1);
    step(20);
    chk("free_idle", ifa.p_busy, 0);
    chk("free_no_word3", hs_a - h0, 2);

    // Load aborts a run mid-FILL
    load_a(26'h155AAAA);
    d0 = done_a;
    start_a(16'd1);
    step(4);
    chk("abort_busy_before", ifa.p_busy, 1);
    load_a(26'h2AAAAAA);
    chk("abort_busy", ifa.p_busy, 0);
    chk("abort_valid", ifa.p_valid, 0);
    chk("abort_state", ifa.p_state, 26'h2AAAAAA);
    step(15);
    chk("abort_no_done", done_a - d0, 0);

    // Async reset in HOLD
    load_a(26'h1234567);
    qa.push_back('{word: 32'h48, st: 32'h3456741, chk_st: 1'b1});
    ifa.p_ready = 1'b0;
    start_a(16'd1);
    wait_for(0, 20, n);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", ifa.p_state, 26'h3FFFFFF);
    chk("arst_valid", ifa.p_valid, 0);
    chk("arst_busy", ifa.p_busy, 0);
    chk("arst_done", ifa.p_done, 0);
    chk("arst_lock_clr", ifa.p_lock_err, 0);
    qa.delete();
    #3 rst_n = 1'b1;
    ifa.p_ready = 1'b1;
    step(3);
    chk("arst_idle", ifa.p_busy, 0);
    chk("b_queue_empty", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1);
  end

endmodule

// File: doc/lfsr_word_gen.md
Name: lfsr_word_gen

Overview:
- Parametrised successor to the team's fixed 26-bit LFSR: configurable width, Fibonacci or Galois feedback, and word-serialised output.
- Packs OUT_W successive output bits into a word and delivers it through a valid/ready handshake.
- Runs either for a programmed number of words or free-running. Adds zero-lockup protection.
- Feeds the scrambler / test-pattern paths of the design.

Parameters:
- WIDTH, 26, LFSR state width (>= 3).
- OUT_W, 8, bits per output word (1..32).
- MODE, 0, 0 = Fibonacci, 1 = Galois.
- FIB_TAPS, 26'h20000C1, Fibonacci tap mask; bit k set means state[k] is XORed into feedback (default = x^26+x^8+x^7+x+1).
- GAL_POLY, 26'h0000183, Galois polynomial low-order coefficients, x^WIDTH implied.
- DEF_SEED, all-ones, replacement seed on zero-lockup.
- CNT_W, 16, width of the run-length counter.

Ports:
- p_clk_in  in  1  clock, rising edge.
- p_rst_n  in  1  asynchronous, active-low reset.
- p_load  in  1  load p_din into state.
- p_din  in  WIDTH  seed value.
- p_start  in  1  begin a run, sampled in IDLE only.
- p_run_len  in  CNT_W  words to produce; 0 = free-run.
- p_stop  in  1  end a free-run at the next word boundary.
- p_word  out  OUT_W  output word.
- p_valid  out  1  p_word valid.
- p_ready  in  1  consumer accepts.
- p_busy  out  1  state != IDLE.
- p_done  out  1  one-cycle pulse at the end of a run.
- p_lock_err  out  1  sticky: a zero seed was replaced.
- p_state  out  WIDTH  current LFSR state (observation).

Behaviour:
- Reset (async, p_rst_n=0):
  - state=DEF_SEED, FSM=IDLE.
  - p_word=0, p_valid=0, p_busy=0, p_done=0, p_lock_err=0.
  - Bit counter and word counter = 0.
- Step function:
  - Out bit = state[WIDTH-1] sampled before the step.
  - Fibonacci: fb = ^(state & FIB_TAPS); next = {state[WIDTH-2:0], fb}.
  - Galois: next = {state[WIDTH-2:0],1'b0} ^ (state[WIDTH-1] ? GAL_POLY : 0).
- Word assembly: the first bit of a word lands in p_word MSB, shifted left per step.
- FSM states: IDLE, FILL, HOLD.
  - IDLE: no stepping. p_start=1 -> FILL; bit_cnt=0, word_cnt=p_run_len.
  - FILL: one step per cycle. After the OUT_W-th step -> HOLD. p_valid=1 in the next cycle, so word latency from start = OUT_W+1 cycles.
  - HOLD: state frozen; p_word and p_valid stable until p_valid&&p_ready. On handshake:
    - Fixed run: decrement word_cnt. If it reaches 0 -> IDLE with p_done=1 for one cycle.
    - Free-run: if stop is pending -> IDLE with p_done pulse; otherwise -> FILL.
    - p_valid drops the cycle after handshake (no back-to-back words; FILL always costs OUT_W cycles).
- p_stop: captured into a pending flag in any non-IDLE state. It only takes effect at the next handshake and is ignored in fixed-length runs. The flag clears on entry to IDLE.
- p_load:
  - Highest priority in every state. Writes the seed, forces IDLE, clears counters, drops p_valid; no p_done.
  - A seed of 0 loads DEF_SEED instead and sets p_lock_err.
- Simultaneous p_load and p_start: load wins and start is ignored.
- p_start outside IDLE is ignored.
- Galois with an all-zero state cannot occur; zero is only reachable via load and is caught there.
- p_lock_err is cleared only by reset.
- Counter widths: bit_cnt uses clog2(OUT_W+1) bits; word_cnt uses CNT_W bits with no wrap. Free-run never decrements.

Decomposition:
- Package lfsr_pkg: FSM state enum (IDLE/FILL/HOLD), MODE_FIB/MODE_GAL constants, default tap/poly constants for widths 8, 16, 26, 32.
- One sub-module, lfsr_step: combinational next-state and out-bit function, parametrised by WIDTH/MODE/taps. It is reused by the checker model.

Test Plan:
- Defaults, load 26'h3FFFFFF, start, p_run_len=1, p_ready=1 -> p_valid at cycle 9 after start, p_word=8'hFF, p_done pulses one cycle after handshake, p_busy=0 after.
- WIDTH=8, MODE=1, GAL_POLY=8'h1D, load 8'h01, run 1 word -> p_word=8'h01, p_state=8'h1D.
- Load 0 -> p_state=DEF_SEED, p_lock_err=1 and stays 1 across a later valid load; clears only on p_rst_n=0.
- Run 3 words with p_ready held low 5 cycles in the first HOLD -> p_word and p_state stable throughout, exactly 3 handshakes, one p_done.
- Free-run, assert p_stop mid-FILL of word 2 -> word 2 still delivered, then IDLE + p_done, with no word 3.
- Assert p_load mid-FILL, and separately p_rst_n low mid-HOLD -> immediate IDLE, p_valid=0, no p_done; reset gives state=DEF_SEED asynchronously.
